// File: rtl/key_pulse_conditioner.sv
// Pushbutton input stage: synchronise, debounce, one pulse per press,
// optional auto-repeat while held, saturating press counter.
module key_pulse_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int CNT_W           = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_n,
   input  logic       repeat_en,
   output logic       key_level,
   output logic       key_pulse,
   output logic [7:0] press_count
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_CHK,
      HELD,
      REPEAT,
      REL_CHK
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   key_s;
   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       timer_q;
   logic                   reload_d;
   logic                   pulse_d;
   logic                   fire_d;
   logic                   level_d;

   // Released key reads as 1, so reset the synchroniser to the idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      end
   end

   assign key_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d  = state_q;
      reload_d = 1'b0;
      pulse_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!key_s) state_d = PRESS_CHK;
         end
         PRESS_CHK: begin
            if (key_s) begin
               state_d = IDLE;
            end else if (timer_q == DB_LAST) begin
               state_d = HELD;
               pulse_d = 1'b1;
            end
         end
         HELD: begin
            if (key_s) begin
               state_d = REL_CHK;
            end else if (repeat_en && timer_q == RD_LAST) begin
               state_d = REPEAT;
               pulse_d = 1'b1;
            end
         end
         REPEAT: begin
            if (key_s) begin
               state_d = REL_CHK;
            end else if (!repeat_en) begin
               state_d = HELD;
            end else if (timer_q == RP_LAST) begin
               reload_d = 1'b1;
               pulse_d  = 1'b1;
            end
         end
         REL_CHK: begin
            if (!key_s) begin
               state_d = HELD;
            end else if (timer_q == DB_LAST) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Guard keeps the strobe one cycle wide even with 1-cycle timings.
   assign fire_d  = pulse_d && !key_pulse;
   assign level_d = (state_d == HELD) || (state_d == REPEAT) ||
                    (state_d == REL_CHK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         if (reload_d || state_d != state_q) begin
            timer_q <= '0;
         end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_level   <= 1'b0;
         key_pulse   <= 1'b0;
         press_count <= '0;
      end else begin
         key_level <= level_d;
         key_pulse <= fire_d;
         if (fire_d && press_count != 8'hFF) begin
            press_count <= press_count + 8'd1;
         end
      end
   end

endmodule
